// File: rtl/trv_mem_arbiter.sv
// Round-robin arbiter sharing one tagged memory request/response channel among
// NUM_REQ traversal units, with a per-requester cap on in-flight requests.
module trv_mem_arbiter #(
    parameter int unsigned NUM_REQ         = 4,
    parameter int unsigned REQ_WIDTH       = 64,
    parameter int unsigned RESP_WIDTH      = 256,
    parameter int unsigned MAX_OUTSTANDING = 4,
    localparam int unsigned TAG_WIDTH      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                            clk,
    input  logic                            arst_n,
    input  logic                            req_empty_n      [0:NUM_REQ-1],
    output logic                            req_read         [0:NUM_REQ-1],
    input  logic [REQ_WIDTH-1:0]            req_dout         [0:NUM_REQ-1],
    input  logic                            mem_req_full_n,
    output logic                            mem_req_write,
    output logic [TAG_WIDTH+REQ_WIDTH-1:0]  mem_req_din,
    input  logic                            mem_resp_empty_n,
    output logic                            mem_resp_read,
    input  logic [TAG_WIDTH+RESP_WIDTH-1:0] mem_resp_dout,
    input  logic                            resp_full_n      [0:NUM_REQ-1],
    output logic                            resp_write       [0:NUM_REQ-1],
    output logic [RESP_WIDTH-1:0]           resp_din         [0:NUM_REQ-1]
);

    localparam int unsigned CNT_WIDTH = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(MAX_OUTSTANDING);

    logic [TAG_WIDTH-1:0]  rr_ptr;
    logic [CNT_WIDTH-1:0]  cnt       [0:NUM_REQ-1];
    logic                  eligible  [0:NUM_REQ-1];
    logic                  grant_vld;
    logic [TAG_WIDTH-1:0]  grant_idx;
    logic                  issue;

    logic [TAG_WIDTH-1:0]  resp_tag;
    logic [RESP_WIDTH-1:0] resp_payload;
    logic                  tag_ok;
    logic                  tgt_ready;

    // A requester competes only while it has data and spare credit
    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            eligible[i] = req_empty_n[i] && (cnt[i] < CNT_MAX);
        end
    end

    // First eligible requester at or after rr_ptr, wrapping modulo NUM_REQ
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!grant_vld && eligible[TAG_WIDTH'((32'(rr_ptr) + k) % NUM_REQ)]) begin
                grant_vld = 1'b1;
                grant_idx = TAG_WIDTH'((32'(rr_ptr) + k) % NUM_REQ);
            end
        end
    end

    assign issue = arst_n && grant_vld && mem_req_full_n;

    always_comb begin
        mem_req_write = issue;
        mem_req_din   = {grant_idx, req_dout[grant_idx]};
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            req_read[i] = issue && (grant_idx == TAG_WIDTH'(i));
        end
    end

    assign resp_tag     = mem_resp_dout[TAG_WIDTH+RESP_WIDTH-1 -: TAG_WIDTH];
    assign resp_payload = mem_resp_dout[RESP_WIDTH-1:0];

    // Out-of-range tags match no requester and are therefore always ready (dropped)
    always_comb begin
        tag_ok    = 1'b0;
        tgt_ready = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (resp_tag == TAG_WIDTH'(i)) begin
                tag_ok    = 1'b1;
                tgt_ready = resp_full_n[i];
            end
        end
    end

    always_comb begin
        mem_resp_read = arst_n && mem_resp_empty_n && (!tag_ok || tgt_ready);
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            resp_write[i] = arst_n && mem_resp_empty_n && (resp_tag == TAG_WIDTH'(i))
                            && resp_full_n[i];
            resp_din[i]   = resp_payload;
        end
    end

    // Pointer moves just past the winner so it gets lowest priority next time
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            rr_ptr <= '0;
        end else if (issue) begin
            rr_ptr <= (grant_idx == TAG_WIDTH'(NUM_REQ - 1)) ? '0 : grant_idx + TAG_WIDTH'(1);
        end
    end

    // Credit counters: issue adds, delivery removes, both together cancel
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                case ({req_read[i], resp_write[i]})
                    2'b10:   if (cnt[i] != CNT_MAX) cnt[i] <= cnt[i] + CNT_WIDTH'(1);
                    2'b01:   if (cnt[i] != '0)      cnt[i] <= cnt[i] - CNT_WIDTH'(1);
                    default: cnt[i] <= cnt[i];
                endcase
            end
        end
    end

`ifndef SYNTHESIS
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_chk
        a_no_underflow: assert property (@(posedge clk) disable iff (!arst_n)
            !(resp_write[gi] && (cnt[gi] == '0)));
    end

    a_tag_range: assert property (@(posedge clk) disable iff (!arst_n)
        !(mem_resp_empty_n && !tag_ok));
`endif

endmodule
